// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell reused over DATA_WIDTH cycles, LSB first.
// Optional macro SUB_SIGNED_OVF_EN adds a two's-complement overflow flag output (ovf).
module serial_ripple_subtractor #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   diff,
    output logic                  busy
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  res_q;
    logic          br_q;
    logic [CW-1:0] cnt_q;
    logic          xfer_q;
    logic [W:0]    diff_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          diff_bit_d;
    logic          br_d;
`ifdef SUB_SIGNED_OVF_EN
    logic          a_sign_q;
    logic          b_sign_q;
    logic          ovf_q;
`endif

    // Full-subtractor cell on the current LSBs of the operand shift registers
    always_comb begin
        diff_bit_d = a_q[0] ^ b_q[0] ^ br_q;
        br_d       = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    end

    // Control FSM and datapath; xfer_q marks the extra BUSY edge that moves the result out
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_q         <= {W{1'b0}};
            b_q         <= {W{1'b0}};
            res_q       <= {W{1'b0}};
            br_q        <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            xfer_q      <= 1'b0;
            diff_q      <= {(W+1){1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            a_sign_q    <= 1'b0;
            b_sign_q    <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        br_q       <= 1'b0;
                        cnt_q      <= {CW{1'b0}};
                        xfer_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_BUSY;
`ifdef SUB_SIGNED_OVF_EN
                        a_sign_q   <= a[W-1];
                        b_sign_q   <= b[W-1];
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (xfer_q) begin
                        diff_q      <= {br_q, res_q};
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        cnt_q       <= {CW{1'b0}};
                        xfer_q      <= 1'b0;
                        state_q     <= ST_DONE;
`ifdef SUB_SIGNED_OVF_EN
                        ovf_q       <= (a_sign_q != b_sign_q) && (res_q[W-1] != a_sign_q);
`endif
                    end else begin
                        a_q   <= {1'b0, a_q[W-1:1]};
                        b_q   <= {1'b0, b_q[W-1:1]};
                        res_q <= {diff_bit_d, res_q[W-1:1]};
                        br_q  <= br_d;
                        if (cnt_q == CNT_LAST) begin
                            xfer_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    xfer_q      <= 1'b0;
                    cnt_q       <= {CW{1'b0}};
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign diff      = diff_q;
`ifdef SUB_SIGNED_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboard bench for serial_ripple_subtractor: directed vectors with hand-computed results.
module tb_serial_ripple_subtractor;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW:0]   diff;
    logic          busy;
`ifdef SUB_SIGNED_OVF_EN
    logic          ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // expected entry: {ovf, diff}
    logic [DW+1:0] exp_q[$];

    serial_ripple_subtractor #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .busy      (busy)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output handshake
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got diff 0x%0h expected no output", diff);
            end else begin
                logic [DW+1:0] e;
                e = exp_q.pop_front();
                chk("diff", 32'(diff), 32'(e[DW:0]));
`ifdef SUB_SIGNED_OVF_EN
                chk("ovf", 32'(ovf), 32'(e[DW+1]));
`endif
            end
        end
    end

    // Present operands and return #1 after the accept edge
    task automatic send(input logic [DW-1:0] va, input logic [DW-1:0] vb,
                        input logic [DW:0] ediff, input logic eovf, input bit push);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) chk("send_timeout_in_ready", 32'(in_ready), 32'd1);
        if (push) exp_q.push_back({eovf, ediff});
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~va;
        b = ~vb;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || !in_ready) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        logic [DW-1:0] va;
        logic [DW-1:0] vb;
        logic [DW:0]   ed;
        logic          eo;
    } vec_t;

    vec_t vecs[9] = '{
        '{8'h03, 8'h05, 9'h1FE, 1'b0},
        '{8'h00, 8'h00, 9'h000, 1'b0},
        '{8'hFF, 8'h00, 9'h0FF, 1'b0},
        '{8'h00, 8'hFF, 9'h101, 1'b0},
        '{8'hFF, 8'hFF, 9'h000, 1'b0},
        '{8'hA5, 8'h5A, 9'h04B, 1'b1},
        '{8'h80, 8'h01, 9'h07F, 1'b1},
        '{8'h7F, 8'hFF, 9'h180, 1'b1},
        '{8'h05, 8'h03, 9'h002, 1'b0}
    };

    initial begin
        int k;
        bit seen;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
`ifdef SUB_SIGNED_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif

        // Latency and flag profile around one operation
        send(8'h05, 8'h03, 9'h002, 1'b0, 1'b1);
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk); #1;
            chk("lat_in_ready", 32'(in_ready), 32'd0);
            chk("lat_busy", 32'(busy), (e < 9) ? 32'd1 : 32'd0);
            chk("lat_out_valid", 32'(out_valid), (e == 9) ? 32'd1 : 32'd0);
        end
        wait_drain();

        foreach (vecs[i]) begin
            send(vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eo, 1'b1);
            wait_drain();
        end

        // Backpressure: result held while in_valid is pulsed
        out_ready = 1'b0;
        send(8'h05, 8'h03, 9'h002, 1'b0, 1'b1);
        k = 0;
        while (!out_valid && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        chk("bp_out_valid_rise", 32'(out_valid), 32'd1);
        a = 8'h22;
        b = 8'h11;
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0] ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            chk("bp_diff_hold", 32'(diff), 32'h002);
            chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_handshake_in_ready", 32'(in_ready), 32'd1);
        chk("bp_handshake_out_valid", 32'(out_valid), 32'd0);
        chk("bp_handshake_busy", 32'(busy), 32'd0);
        exp_q.push_back({1'b0, 9'h011});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accept_busy", 32'(busy), 32'd1);
        chk("bp_accept_in_ready", 32'(in_ready), 32'd0);
        wait_drain();

        // Reset after four BUSY edges aborts the operation
        send(8'h5A, 8'h11, 9'h049, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_pulse", 32'(seen), 32'd0);
        send(8'h10, 8'h01, 9'h00F, 1'b0, 1'b1);
        wait_drain();

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
